// File: rtl/pal_bus_arb.sv
// pal_bus_arb -- round-robin arbiter for N requesters sharing one 8-bit
// tri-state bus. Each requester owns a register whose bufif0 drivers are
// enabled by oe_n. A grant runs IDLE -> LOAD -> DRIVE -> TURN -> IDLE so the
// bus always has all drivers off between two owners.
//
// Ports:
//   clk      sole clock, all state updates on posedge
//   rst      asynchronous active-high reset
//   req[N]   per-requester bus request (level)
//   done[N]  per-requester release, only the granted bit is looked at
//   ld[N]    one-cycle load strobe for the granted register (LOAD)
//   oe_n[N]  active-low bus driver enable for the granted register (DRIVE)
//   gnt[N]   one-hot grant, high during DRIVE
//   busy     high whenever the FSM is not in IDLE
//   timeout  one-cycle pulse in the first TURN cycle of a revoked grant
module pal_bus_arb #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  parameter int TURN_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] ld,
  output logic [N-1:0] oe_n,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic         timeout
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  localparam logic [3:0]   HOLD_LIM = 4'(HOLD_MAX);
  localparam logic [1:0]   TURN_LIM = 2'(TURN_CYC);
  localparam logic [N-1:0] ONE_LSB  = N'(1'b1);
  localparam logic [N-1:0] ALL_ZERO = {N{1'b0}};
  localparam logic [N-1:0] ALL_ONE  = {N{1'b1}};

  // Round-robin pick: {found, index}. Offsets are scanned from farthest to
  // nearest so the requester closest above p overwrites the others; offset N
  // is p itself, which therefore has the lowest priority.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] r,
                                          input logic [PW-1:0] p);
    logic [PW:0]   res;
    logic [PW-1:0] idx;
    res = {(PW+1){1'b0}};
    for (int i = N; i >= 1; i--) begin
      idx = PW'((int'(p) + i) % N);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;       // last winner; doubles as current grant index
  logic [3:0]    hold_q, hold_d;
  logic [1:0]    turn_q, turn_d;
  logic [N-1:0]  ld_q, ld_d;
  logic [N-1:0]  oe_n_q, oe_n_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [PW:0]   pick;
  logic          release_s;

  assign pick      = rr_pick(req, ptr_q);
  assign release_s = done[ptr_q] | ~req[ptr_q];

  // Next-state, pointer and counter logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick[PW]) begin
          state_d = S_LOAD;
          ptr_d   = pick[PW-1:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_DRIVE;
        hold_d  = 4'd1;
      end
      S_DRIVE: begin
        // Release is tested first so it wins over a coincident hold limit.
        if (release_s) begin
          state_d = S_TURN;
          turn_d  = 2'd1;
        end else if (hold_q >= HOLD_LIM) begin
          state_d   = S_TURN;
          turn_d    = 2'd1;
          timeout_d = 1'b1;
        end else if (hold_q != 4'hF) begin
          hold_d = hold_q + 4'd1;
        end else begin
          hold_d = hold_q;
        end
      end
      S_TURN: begin
        if (turn_q >= TURN_LIM) begin
          state_d = S_IDLE;
        end else begin
          turn_d = turn_q + 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered and
  // still line up with the state they describe.
  always_comb begin
    ld_d   = ALL_ZERO;
    oe_n_d = ALL_ONE;
    gnt_d  = ALL_ZERO;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_LOAD: begin
        ld_d = ONE_LSB << ptr_d;
      end
      S_DRIVE: begin
        oe_n_d = ~(ONE_LSB << ptr_d);
        gnt_d  = ONE_LSB << ptr_d;
      end
      default: begin
        ld_d = ALL_ZERO;
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= PW'(N - 1);
      hold_q    <= 4'd0;
      turn_q    <= 2'd0;
      ld_q      <= ALL_ZERO;
      oe_n_q    <= ALL_ONE;
      gnt_q     <= ALL_ZERO;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
      ld_q      <= ld_d;
      oe_n_q    <= oe_n_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign ld      = ld_q;
  assign oe_n    = oe_n_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_pal_bus_arb.sv
// Testbench for pal_bus_arb (N=4, HOLD_MAX=8, TURN_CYC=1). Inputs change 1ns
// after posedge; outputs are sampled at that same point, i.e. away from the
// edge. Expected per-cycle output vectors and expected grant winners are
// queued when stimulus is applied and popped when the DUT responds.
module tb_pal_bus_arb;
  localparam int N        = 4;
  localparam int HOLD_MAX = 8;
  localparam int TURN_CYC = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, done, ld, oe_n, gnt;
  logic       busy, timeout;
  logic [13:0] obs;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [13:0] exp_q[$];
  int          win_q[$];

  localparam logic [13:0] IDLE_VEC = {4'h0, 4'hF, 4'h0, 1'b0, 1'b0};

  pal_bus_arb #(.N(N), .HOLD_MAX(HOLD_MAX), .TURN_CYC(TURN_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .ld(ld), .oe_n(oe_n), .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  assign obs = {ld, oe_n, gnt, busy, timeout};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; req = 4'h0; done = 4'h0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 4'hF; done = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests_run++;
      if (obs !== IDLE_VEC) begin
        tests_failed++;
        $display("FAIL reset_hold: got %h expected %h", obs, IDLE_VEC);
      end
    end
    req = 4'h0;
    tick;
    rst = 1'b0;
    tick;
    tests_run++;
    if (obs !== IDLE_VEC) begin
      tests_failed++;
      $display("FAIL reset_idle_after: got %h expected %h", obs, IDLE_VEC);
    end
  endtask

  task automatic test_single;
    logic [3:0]  t_req[6]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic [3:0]  t_done[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    logic [13:0] t_exp[6]  = '{
      {4'b0100, 4'hF,    4'h0,    1'b1, 1'b0},   // cycle 1 LOAD
      {4'b0000, 4'b1011, 4'b0100, 1'b1, 1'b0},   // cycle 2 DRIVE 1
      {4'b0000, 4'b1011, 4'b0100, 1'b1, 1'b0},   // cycle 3 DRIVE 2
      {4'b0000, 4'b1011, 4'b0100, 1'b1, 1'b0},   // cycle 4 DRIVE 3
      {4'b0000, 4'hF,    4'h0,    1'b1, 1'b0},   // cycle 5 TURN
      {4'b0000, 4'hF,    4'h0,    1'b0, 1'b0}};  // cycle 6 IDLE
    logic [13:0] e;
    for (int k = 0; k < 6; k++) begin
      req = t_req[k];
      done = t_done[k];
      exp_q.push_back(t_exp[k]);
      tick;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL single_cycle%0d: got %h expected %h", k + 1, obs, e);
      end
    end
    req = 4'h0; done = 4'h0;
  endtask

  task automatic test_round_robin;
    int         order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] prev_oe;
    int         off_run, windows, w;
    apply_reset;
    req = 4'hF; done = 4'h0;
    foreach (order[k]) win_q.push_back(order[k]);
    prev_oe = 4'hF; off_run = 0; windows = 0;
    for (int c = 0; c < 80 && windows < 5; c++) begin
      tick;
      done = 4'h0;
      tests_run++;
      if ($countones(~oe_n) > 1) begin
        tests_failed++;
        $display("FAIL rr_one_driver: got oe_n=%b expected at most one low", oe_n);
      end
      if (oe_n != 4'hF && prev_oe == 4'hF) begin
        windows++;
        w = win_q.pop_front();
        tests_run++;
        if (gnt !== (4'b0001 << w)) begin
          tests_failed++;
          $display("FAIL rr_grant%0d: got %b expected %b", windows, gnt, 4'b0001 << w);
        end
        if (windows > 1) begin
          // off cycles between windows: TURN_CYC turnaround, then IDLE, LOAD
          tests_run++;
          if (off_run != TURN_CYC + 2) begin
            tests_failed++;
            $display("FAIL rr_gap%0d: got %0d expected %0d", windows, off_run, TURN_CYC + 2);
          end
        end
        done = gnt;
      end
      if (oe_n == 4'hF) off_run++;
      else off_run = 0;
      prev_oe = oe_n;
    end
    tests_run++;
    if (windows != 5) begin
      tests_failed++;
      $display("FAIL rr_budget: got %0d windows expected 5", windows);
    end
    win_q.delete();
    req = 4'h0; done = 4'h0;
  endtask

  task automatic test_timeout;
    logic [3:0] prev_oe;
    int         low_len, first_len, windows, to_cnt, w;
    apply_reset;
    req = 4'b0010; done = 4'h0;
    win_q.push_back(1); win_q.push_back(1);
    prev_oe = 4'hF; low_len = 0; first_len = -1; windows = 0; to_cnt = 0;
    for (int c = 0; c < 60 && windows < 2; c++) begin
      tick;
      if (timeout) begin
        to_cnt++;
        tests_run++;
        if (!(oe_n == 4'hF && prev_oe != 4'hF)) begin
          tests_failed++;
          $display("FAIL to_align: got oe_n=%b prev=%b expected first off cycle", oe_n, prev_oe);
        end
      end
      if (oe_n != 4'hF && prev_oe == 4'hF) begin
        windows++;
        w = win_q.pop_front();
        tests_run++;
        if (gnt !== (4'b0001 << w)) begin
          tests_failed++;
          $display("FAIL to_grant%0d: got %b expected %b", windows, gnt, 4'b0001 << w);
        end
      end
      if (oe_n != 4'hF) low_len++;
      else if (prev_oe != 4'hF && first_len < 0) first_len = low_len;
      prev_oe = oe_n;
    end
    tests_run++;
    if (first_len != HOLD_MAX) begin
      tests_failed++;
      $display("FAIL to_len: got %0d expected %0d", first_len, HOLD_MAX);
    end
    tests_run++;
    if (to_cnt != 1) begin
      tests_failed++;
      $display("FAIL to_pulses: got %0d expected 1", to_cnt);
    end
    tests_run++;
    if (windows != 2) begin
      tests_failed++;
      $display("FAIL to_regrant: got %0d windows expected 2", windows);
    end
    win_q.delete();
    req = 4'h0; done = 4'h0;
  endtask

  task automatic test_simultaneous;
    int drv;
    bit seen;
    logic [13:0] e;
    apply_reset;
    req = 4'b0010; done = 4'h0;
    drv = 0; seen = 1'b0;
    exp_q.push_back({4'h0, 4'hF, 4'h0, 1'b1, 1'b0});
    for (int c = 0; c < 30 && !seen; c++) begin
      tick;
      if (drv == HOLD_MAX) begin
        e = exp_q.pop_front();
        seen = 1'b1;
        tests_run++;
        if (obs !== e) begin
          tests_failed++;
          $display("FAIL sim_turn: got %h expected %h", obs, e);
        end
      end else if (oe_n != 4'hF) begin
        drv++;
        if (drv == HOLD_MAX) done = 4'b0010;
      end else if (drv > 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sim_early: got %0d drive cycles expected %0d", drv, HOLD_MAX);
        drv = 0;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL sim_budget: got no turn expected turn after %0d cycles", HOLD_MAX);
    end
    exp_q.delete();
    req = 4'h0; done = 4'h0;
  endtask

  task automatic test_ignore;
    int low_len;
    apply_reset;
    req = 4'h0; done = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick;
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL ign_idle_done: got busy=%b expected 0", busy);
      end
    end
    req = 4'b0001;
    tick;
    tests_run++;
    if (ld !== 4'b0001) begin
      tests_failed++;
      $display("FAIL ign_load: got ld=%b expected 0001", ld);
    end
    done = 4'b0001;   // only visible while in LOAD
    tick;
    done = 4'b1110;   // non-granted releases for the whole DRIVE phase
    low_len = (oe_n == 4'b1110) ? 1 : 0;
    for (int c = 0; c < 30; c++) begin
      tick;
      if (oe_n != 4'hF) low_len++;
      else break;
    end
    tests_run++;
    if (low_len != HOLD_MAX) begin
      tests_failed++;
      $display("FAIL ign_len: got %0d expected %0d", low_len, HOLD_MAX);
    end
    tests_run++;
    if (timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL ign_timeout: got %b expected 1", timeout);
    end
    req = 4'h0; done = 4'h0;
  endtask

  task automatic test_reset_mid;
    bit found;
    int w;
    apply_reset;
    req = 4'hF; done = 4'h0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick;
      done = 4'h0;
      if (gnt == 4'b0100) found = 1'b1;
      else if (gnt != 4'h0) done = gnt;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL rm_budget: got no grant expected grant to 2");
    end
    tick;                   // second DRIVE cycle of requester 2
    #3 rst = 1'b1;          // mid-cycle, no clock edge involved
    #1;
    tests_run++;
    if (obs !== IDLE_VEC) begin
      tests_failed++;
      $display("FAIL rm_async: got %h expected %h", obs, IDLE_VEC);
    end
    tick;
    tests_run++;
    if (timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_no_timeout: got %b expected 0", timeout);
    end
    #3 rst = 1'b0;
    win_q.push_back(0);
    tick;
    tests_run++;
    if (ld !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rm_first_load: got ld=%b expected 0001", ld);
    end
    tick;
    w = win_q.pop_front();
    tests_run++;
    if (gnt !== (4'b0001 << w)) begin
      tests_failed++;
      $display("FAIL rm_grant: got %b expected %b", gnt, 4'b0001 << w);
    end
    req = 4'h0; done = 4'h0;
    for (int i = 0; i < 12; i++) tick;
  endtask

  initial begin
    rst = 1'b1; req = 4'h0; done = 4'h0;
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_simultaneous;
    test_ignore;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
